mult_arbiter: RTL and testbench
===============================

# mult_arbiter

Round-robin arbiter that shares one pipelined signed 27x27 multiplier (`mult_27`) among `N_REQ` requesters in the `ik_swift_32` datapath. It accepts at most one operand pair per cycle and registers the operands into the multiplier. A tag pipeline matched to the multiplier latency tracks each in-flight product. Each product is returned to its originating requester on a one-hot result-valid bus.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `WIDTH`, 27: operand width; the product is `2*WIDTH`.
- `LATENCY`, 4: register stages inside `mult_27`, from registered operands to `mult_result`.

Ports:
- `clk` in 1: single clock; every register is on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `req_valid` in N_REQ: per-requester operand-valid.
- `req_a` in N_REQ*WIDTH: flattened signed operand A. Requester i uses bits [i*WIDTH +: WIDTH].
- `req_b` in N_REQ*WIDTH: flattened signed operand B, same packing.
- `req_ready` out N_REQ: one-hot grant, combinational from `req_valid` and the priority pointer.
- `mult_dataa` out WIDTH: registered operand A to `mult_27`.
- `mult_datab` out WIDTH: registered operand B to `mult_27`.
- `mult_result` in 2*WIDTH: product from `mult_27`.
- `res_valid` out N_REQ: one-hot, one-cycle pulse marking a delivered result.
- `res_data` out 2*WIDTH: registered product, broadcast to all requesters.
- `busy` out 1: high while any product is in flight or a result is being presented.

## Operation
- **Arbitration**
  - Priority pointer `ptr` ranges 0..N_REQ-1.
  - The grant goes to the first i with `req_valid[i]=1`, scanning ptr, ptr+1, … (mod N_REQ).
  - `req_ready` is zero when no request is valid.
- **Handshake**
  - A transfer occurs in a cycle where `req_valid[i] & req_ready[i]`.
  - A requester holds a, b and valid stable until it sees ready.
  - Dropping valid before ready is legal; no state is kept for that request.
- **Pointer update**
  - On a transfer from i: `ptr <= (i+1) mod N_REQ`.
  - With no transfer, `ptr` holds.
  - A sole requester holding valid is accepted every cycle.
- **Issue**
  - On a transfer: `mult_dataa`/`mult_datab` load the granted operands.
  - The tag pipeline stage 0 loads {valid=1, idx=i}.
  - Without a transfer: the operand registers hold their value, and stage 0 loads valid=0.
- **Tag pipeline**
  - LATENCY+1 stages of {valid, idx}, shifting every cycle. There is no stall.
  - The last stage's valid aligns with `mult_result` being the product of that tag's operands.
- **Result**
  - When the last tag stage is valid: `res_data <= mult_result` and `res_valid <= one-hot(idx)`.
  - Otherwise `res_valid <= 0` and `res_data` holds.
- **Arithmetic**
  - Two's-complement signed, full-precision `2*WIDTH` product, with no rounding or saturation.
- **Result flow control**
  - There is no backpressure on results. Requesters must accept `res_valid` unconditionally.
- **busy**
  - busy = OR of all tag-stage valids OR any bit of `res_valid`.

## Timing
- **Reset** (`reset_n` low at a rising edge):
  - `ptr=0`
  - all tag valids 0
  - `res_valid=0`
  - `res_data=0`
  - `mult_dataa=0`, `mult_datab=0`
  - `busy=0`
  - `req_ready` is forced to 0 while `reset_n` is low.
- **Reset mid-operation**
  - All in-flight products are discarded; no `res_valid` appears for them.
  - After release, `mult_result` garbage is ignored because the tags are cleared.
- **Latency**
  - A transfer in cycle t gives `res_valid` high in cycle t+LATENCY+2, i.e. cycle t+6 at the defaults.
  - The result is present for exactly one cycle.
- **Throughput**
  - One transfer per cycle. Results return in acceptance order.
- **Simultaneous events**
  - A new transfer and a result delivery in the same cycle are independent.
  - A requester may have multiple products in flight at once.
- **Wrap-around**
  - A grant to N_REQ-1 sets `ptr=0`.

## Test plan
1. **Single request**
   - Stimulus: req0 with a=3, b=-5, accepted in cycle t.
   - Required: `res_valid=4'b0001` in cycle t+6 only; `res_data=-15`.
2. **Full contention**
   - Stimulus: all four requesters hold valid for 8 cycles.
   - Required: grants 0,1,2,3,0,1,2,3 on consecutive cycles.
   - Required: `res_valid` follows the same order, each 6 cycles after its grant, with the correct products.
3. **Pointer skip**
   - Stimulus: `ptr=2`, and only req1 and req3 are valid.
   - Required: req3 is granted first, then req1 next cycle; `ptr` ends at 2.
4. **Extremes**
   - Stimulus: a=b=-2^26.
   - Required: `res_data=2^52`.
   - Stimulus: a=-2^26, b=2^26-1.
   - Required: `res_data=-2^52+2^26`.
5. **Reset mid-flight**
   - Stimulus: 3 products in flight; `reset_n` pulsed low for one cycle.
   - Required: no `res_valid` for 10 cycles after; `busy=0`; the next grant goes to the lowest-index valid requester.
6. **Streaming single requester**
   - Stimulus: req2 alone with valid held for 5 cycles, operands incrementing.
   - Required: 5 consecutive accepts and 5 consecutive `res_valid=4'b0100` pulses with matching products.

Source files
------------

// File: rtl/mult_arbiter_if.sv
// Requester, multiplier and result signals of mult_arbiter.
// The arbiter uses the slave view; the surrounding datapath uses the master view.
interface mult_arbiter_if #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned WIDTH = 27
);
   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ*WIDTH-1:0] req_a;
   logic [N_REQ*WIDTH-1:0] req_b;
   logic [N_REQ-1:0]       req_ready;
   logic [WIDTH-1:0]       mult_dataa;
   logic [WIDTH-1:0]       mult_datab;
   logic [2*WIDTH-1:0]     mult_result;
   logic [N_REQ-1:0]       res_valid;
   logic [2*WIDTH-1:0]     res_data;
   logic                   busy;

   modport slave (
      input  req_valid, req_a, req_b, mult_result,
      output req_ready, mult_dataa, mult_datab, res_valid, res_data, busy
   );

   modport master (
      output req_valid, req_a, req_b, mult_result,
      input  req_ready, mult_dataa, mult_datab, res_valid, res_data, busy
   );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one pipelined signed multiplier among N_REQ requesters.
// A tag pipeline rides alongside the multiplier so each product returns to its issuer.
module mult_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned WIDTH   = 27,
   parameter int unsigned LATENCY = 4
) (
   input logic           clk,
   input logic           reset_n,
   mult_arbiter_if.slave bus
);
   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned PW    = 2 * WIDTH;
   localparam int unsigned NSTG  = LATENCY + 1;

   logic [IDX_W-1:0]           ptr_q, ptr_d;
   logic [WIDTH-1:0]           dataa_q, dataa_d;
   logic [WIDTH-1:0]           datab_q, datab_d;
   logic [NSTG-1:0]            tag_vld_q, tag_vld_d;
   logic [NSTG-1:0][IDX_W-1:0] tag_idx_q, tag_idx_d;
   logic [N_REQ-1:0]           res_valid_q, res_valid_d;
   logic [PW-1:0]              res_data_q, res_data_d;

   logic [N_REQ-1:0]           gnt_c;
   logic [IDX_W-1:0]           gnt_idx_c;
   logic [IDX_W-1:0]           scan_idx_c;
   logic                       gnt_any_c;

   // First valid requester at or after ptr wins; nothing is granted while in reset.
   always_comb begin
      gnt_c      = '0;
      gnt_idx_c  = '0;
      scan_idx_c = '0;
      gnt_any_c  = 1'b0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         scan_idx_c = IDX_W'((32'(ptr_q) + k) % N_REQ);
         if (reset_n && !gnt_any_c && bus.req_valid[scan_idx_c]) begin
            gnt_c[scan_idx_c] = 1'b1;
            gnt_idx_c         = scan_idx_c;
            gnt_any_c         = 1'b1;
         end
      end
   end

   // Issue, tag shift and result capture; the tag shifts every cycle, no stall.
   always_comb begin
      ptr_d       = ptr_q;
      dataa_d     = dataa_q;
      datab_d     = datab_q;
      tag_vld_d   = {tag_vld_q[NSTG-2:0], gnt_any_c};
      tag_idx_d   = {tag_idx_q[NSTG-2:0], gnt_idx_c};
      res_valid_d = '0;
      res_data_d  = res_data_q;

      if (gnt_any_c) begin
         ptr_d   = (gnt_idx_c == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx_c + 1'b1;
         dataa_d = bus.req_a[32'(gnt_idx_c) * WIDTH +: WIDTH];
         datab_d = bus.req_b[32'(gnt_idx_c) * WIDTH +: WIDTH];
      end

      if (tag_vld_q[NSTG-1]) begin
         res_valid_d[tag_idx_q[NSTG-1]] = 1'b1;
         res_data_d                     = bus.mult_result;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ptr_q       <= '0;
         dataa_q     <= '0;
         datab_q     <= '0;
         tag_vld_q   <= '0;
         tag_idx_q   <= '0;
         res_valid_q <= '0;
         res_data_q  <= '0;
      end else begin
         ptr_q       <= ptr_d;
         dataa_q     <= dataa_d;
         datab_q     <= datab_d;
         tag_vld_q   <= tag_vld_d;
         tag_idx_q   <= tag_idx_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
      end
   end

   assign bus.req_ready  = gnt_c;
   assign bus.mult_dataa = dataa_q;
   assign bus.mult_datab = datab_q;
   assign bus.res_valid  = res_valid_q;
   assign bus.res_data   = res_data_q;
   assign bus.busy       = (|tag_vld_q) | (|res_valid_q);
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed self-checking bench for mult_arbiter with a behavioural 4-stage mult_27.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_mult_arbiter;
   localparam int unsigned N_REQ   = 4;
   localparam int unsigned WIDTH   = 27;
   localparam int unsigned LATENCY = 4;
   localparam int unsigned PW      = 2 * WIDTH;

   logic clk = 1'b0;
   logic reset_n;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   mult_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

   mult_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   function automatic logic [PW-1:0] mulx(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic signed [PW-1:0] ea;
      logic signed [PW-1:0] eb;
      ea = {{WIDTH{a[WIDTH-1]}}, a};
      eb = {{WIDTH{b[WIDTH-1]}}, b};
      return ea * eb;
   endfunction

   // Stand-in for mult_27: LATENCY register stages from the operand registers.
   logic [PW-1:0] mpipe [LATENCY];
   always @(posedge clk) begin
      mpipe[0] <= mulx(bus.mult_dataa, bus.mult_datab);
      for (int s = 1; s < LATENCY; s++) mpipe[s] <= mpipe[s-1];
   end
   assign bus.mult_result = mpipe[LATENCY-1];

   task automatic idle();
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
   endtask

   task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      bus.req_valid[i]              = 1'b1;
      bus.req_a[i*WIDTH +: WIDTH]   = a;
      bus.req_b[i*WIDTH +: WIDTH]   = b;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset_n = 1'b0;
      idle();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      idle();
      for (int i = 0; i < 4; i++) set_req(i, WIDTH'(i + 1), WIDTH'(i + 2));
      @(negedge clk);
      #1;
      n_vec++;
      if (bus.req_ready !== 4'b0000) begin
         n_bad++; $display("FAIL reset_ready_forced: got %b expected 0000", bus.req_ready);
      end
      @(negedge clk);
      reset_n = 1'b1;
      idle();
      #1;
      n_vec++;
      if (bus.res_valid !== 4'b0000 || bus.busy !== 1'b0 || bus.req_ready !== 4'b0000) begin
         n_bad++; $display("FAIL reset_ctrl: res_valid=%b busy=%b ready=%b expected 0000/0/0000",
                           bus.res_valid, bus.busy, bus.req_ready);
      end
      n_vec++;
      if (bus.res_data !== '0 || bus.mult_dataa !== '0 || bus.mult_datab !== '0) begin
         n_bad++; $display("FAIL reset_data: res_data=%h dataa=%h datab=%h expected all 0",
                           bus.res_data, bus.mult_dataa, bus.mult_datab);
      end
   endtask

   task automatic test_single();
      for (int c = 0; c <= 8; c++) begin
         @(negedge clk);
         idle();
         if (c == 0) set_req(0, WIDTH'(3), WIDTH'(-5));
         #1;
         if (c == 0) begin
            n_vec++;
            if (bus.req_ready !== 4'b0001) begin
               n_bad++; $display("FAIL single_grant: got %b expected 0001", bus.req_ready);
            end
         end
         if (c == 1) begin
            n_vec++;
            if (bus.mult_dataa !== WIDTH'(3) || bus.mult_datab !== WIDTH'(-5)) begin
               n_bad++; $display("FAIL single_operands: got %h/%h expected 0000003/7fffffb",
                                 bus.mult_dataa, bus.mult_datab);
            end
         end
         n_vec++;
         if (bus.res_valid !== ((c == 6) ? 4'b0001 : 4'b0000)) begin
            n_bad++; $display("FAIL single_res_valid c=%0d: got %b", c, bus.res_valid);
         end
         if (c == 6) begin
            n_vec++;
            if (bus.res_data !== PW'(-15)) begin
               n_bad++; $display("FAIL single_res_data: got %h expected %h", bus.res_data, PW'(-15));
            end
         end
      end
   endtask

   task automatic test_contention();
      logic [3:0]    exp_rv [32];
      logic [PW-1:0] exp_rd [32];
      int            cnt [4];
      logic [3:0]    em;
      int            g;
      for (int k = 0; k < 32; k++) begin exp_rv[k] = '0; exp_rd[k] = '0; end
      for (int k = 0; k < 4; k++) cnt[k] = 0;
      apply_reset();
      for (int c = 0; c <= 14; c++) begin
         @(negedge clk);
         idle();
         if (c < 8)
            for (int i = 0; i < 4; i++)
               set_req(i, WIDTH'(100 * i + cnt[i] + 1), WIDTH'(cnt[i] - 3 - i));
         #1;
         em = 4'b0000;
         if (c < 8) begin
            g = c % 4;
            em = 4'b0001 << g;
            exp_rv[c + 6] = em;
            exp_rd[c + 6] = mulx(WIDTH'(100 * g + cnt[g] + 1), WIDTH'(cnt[g] - 3 - g));
            cnt[g]++;
         end
         n_vec++;
         if (bus.req_ready !== em) begin
            n_bad++; $display("FAIL contention_grant c=%0d: got %b expected %b", c, bus.req_ready, em);
         end
         n_vec++;
         if (bus.res_valid !== exp_rv[c]) begin
            n_bad++; $display("FAIL contention_res_valid c=%0d: got %b expected %b",
                              c, bus.res_valid, exp_rv[c]);
         end
         if (exp_rv[c] != 4'b0000) begin
            n_vec++;
            if (bus.res_data !== exp_rd[c]) begin
               n_bad++; $display("FAIL contention_res_data c=%0d: got %h expected %h",
                                 c, bus.res_data, exp_rd[c]);
            end
         end
         if (c == 10 || c == 14) begin
            n_vec++;
            if (bus.busy !== (c == 10)) begin
               n_bad++; $display("FAIL contention_busy c=%0d: got %b expected %b", c, bus.busy, c == 10);
            end
         end
      end
   endtask

   task automatic test_pointer_skip();
      logic [3:0]    er;
      logic [3:0]    ev;
      logic [PW-1:0] ed;
      apply_reset();
      for (int c = 0; c <= 11; c++) begin
         @(negedge clk);
         idle();
         case (c)
            0: set_req(1, WIDTH'(7), WIDTH'(9));
            1: begin set_req(1, WIDTH'(-8), WIDTH'(4)); set_req(3, WIDTH'(11), WIDTH'(-12)); end
            2: set_req(1, WIDTH'(-8), WIDTH'(4));
            3: begin
               set_req(0, WIDTH'(1), WIDTH'(1)); set_req(1, WIDTH'(2), WIDTH'(2));
               set_req(2, WIDTH'(5), WIDTH'(-6)); set_req(3, WIDTH'(3), WIDTH'(3));
            end
            default: ;
         endcase
         #1;
         case (c)
            0: er = 4'b0010;
            1: er = 4'b1000;
            2: er = 4'b0010;
            3: er = 4'b0100;
            default: er = 4'b0000;
         endcase
         ed = '0;
         case (c)
            6: begin ev = 4'b0010; ed = PW'(63);   end
            7: begin ev = 4'b1000; ed = PW'(-132); end
            8: begin ev = 4'b0010; ed = PW'(-32);  end
            9: begin ev = 4'b0100; ed = PW'(-30);  end
            default: ev = 4'b0000;
         endcase
         n_vec++;
         if (bus.req_ready !== er) begin
            n_bad++; $display("FAIL skip_grant c=%0d: got %b expected %b", c, bus.req_ready, er);
         end
         n_vec++;
         if (bus.res_valid !== ev) begin
            n_bad++; $display("FAIL skip_res_valid c=%0d: got %b expected %b", c, bus.res_valid, ev);
         end
         if (ev != 4'b0000) begin
            n_vec++;
            if (bus.res_data !== ed) begin
               n_bad++; $display("FAIL skip_res_data c=%0d: got %h expected %h", c, bus.res_data, ed);
            end
         end
      end
   endtask

   task automatic test_extremes();
      logic [PW-1:0] ed;
      for (int c = 0; c <= 9; c++) begin
         @(negedge clk);
         idle();
         case (c)
            0: set_req(0, 27'h4000000, 27'h4000000);
            1: set_req(0, 27'h4000000, 27'h3FFFFFF);
            2: set_req(0, 27'h3FFFFFF, 27'h3FFFFFF);
            default: ;
         endcase
         #1;
         if (c <= 2) begin
            n_vec++;
            if (bus.req_ready !== 4'b0001) begin
               n_bad++; $display("FAIL extreme_grant c=%0d: got %b expected 0001", c, bus.req_ready);
            end
         end
         n_vec++;
         if (bus.res_valid !== ((c >= 6 && c <= 8) ? 4'b0001 : 4'b0000)) begin
            n_bad++; $display("FAIL extreme_res_valid c=%0d: got %b", c, bus.res_valid);
         end
         if (c >= 6 && c <= 8) begin
            case (c)
               6:       ed = 54'h10000000000000;
               7:       ed = 54'h30000004000000;
               default: ed = 54'h0FFFFFF8000001;
            endcase
            n_vec++;
            if (bus.res_data !== ed) begin
               n_bad++; $display("FAIL extreme_res_data c=%0d: got %h expected %h", c, bus.res_data, ed);
            end
         end
      end
   endtask

   task automatic test_reset_midflight();
      logic [3:0] er;
      for (int c = 0; c <= 21; c++) begin
         @(negedge clk);
         idle();
         reset_n = 1'b1;
         case (c)
            0: begin
               set_req(0, WIDTH'(2), WIDTH'(2)); set_req(1, WIDTH'(3), WIDTH'(3));
               set_req(2, WIDTH'(4), WIDTH'(4));
            end
            1: begin set_req(0, WIDTH'(2), WIDTH'(2)); set_req(2, WIDTH'(4), WIDTH'(4)); end
            2: set_req(0, WIDTH'(2), WIDTH'(2));
            3: begin reset_n = 1'b0; set_req(3, WIDTH'(9), WIDTH'(9)); end
            14: begin set_req(0, WIDTH'(6), WIDTH'(7)); set_req(3, WIDTH'(5), WIDTH'(5)); end
            default: ;
         endcase
         #1;
         case (c)
            0: er = 4'b0010;
            1: er = 4'b0100;
            2: er = 4'b0001;
            14: er = 4'b0001;
            default: er = 4'b0000;
         endcase
         n_vec++;
         if (bus.req_ready !== er) begin
            n_bad++; $display("FAIL midrst_grant c=%0d: got %b expected %b", c, bus.req_ready, er);
         end
         if (c == 3) begin
            n_vec++;
            if (bus.busy !== 1'b1) begin
               n_bad++; $display("FAIL midrst_busy_before: got %b expected 1", bus.busy);
            end
         end
         if (c >= 4 && c <= 13) begin
            n_vec++;
            if (bus.res_valid !== 4'b0000 || bus.busy !== 1'b0) begin
               n_bad++; $display("FAIL midrst_quiet c=%0d: res_valid=%b busy=%b expected 0000/0",
                                 c, bus.res_valid, bus.busy);
            end
         end
         if (c == 20) begin
            n_vec++;
            if (bus.res_valid !== 4'b0001 || bus.res_data !== PW'(42)) begin
               n_bad++; $display("FAIL midrst_after: res_valid=%b res_data=%h expected 0001/%h",
                                 bus.res_valid, bus.res_data, PW'(42));
            end
         end
      end
   endtask

   task automatic test_streaming();
      int exp_p [5] = '{-10, -22, -36, -52, -70};
      for (int c = 0; c <= 12; c++) begin
         @(negedge clk);
         idle();
         if (c < 5) set_req(2, WIDTH'(10 + c), WIDTH'(-(c + 1)));
         #1;
         n_vec++;
         if (bus.req_ready !== ((c < 5) ? 4'b0100 : 4'b0000)) begin
            n_bad++; $display("FAIL stream_grant c=%0d: got %b", c, bus.req_ready);
         end
         n_vec++;
         if (bus.res_valid !== ((c >= 6 && c <= 10) ? 4'b0100 : 4'b0000)) begin
            n_bad++; $display("FAIL stream_res_valid c=%0d: got %b", c, bus.res_valid);
         end
         if (c >= 6 && c <= 10) begin
            n_vec++;
            if (bus.res_data !== PW'(exp_p[c-6])) begin
               n_bad++; $display("FAIL stream_res_data c=%0d: got %h expected %h",
                                 c, bus.res_data, PW'(exp_p[c-6]));
            end
         end
         if (c == 12) begin
            n_vec++;
            if (bus.busy !== 1'b0) begin
               n_bad++; $display("FAIL stream_busy_end: got %b expected 0", bus.busy);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_pointer_skip();
      test_extremes();
      test_reset_midflight();
      test_streaming();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
